// File: rtl/wave_renderer.sv
// -----------------------------------------------------------------------------
// wave_renderer
//   Renders a multi-channel digital waveform as rectangle commands for a TFT
//   controller. A frame optionally starts with a full-screen background fill,
//   then draws each channel as one horizontal segment per step. A vertical
//   edge is inserted wherever the level changes between adjacent steps of the
//   same channel.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              one-cycle frame request (ignored while busy)
//   clear_en           fill the screen with bg_color before the traces
//   bg_color           RGB565 background colour
//   chan_color         RGB565 per channel, channel c at [16c+15:16c]
//   samples            bit c*STEPS+s = level of channel c at step s
//   draw / draw_done   rectangle request / one-cycle completion pulse
//   color, xstart, ystart, xend, yend   rectangle command
//   busy               frame in progress
//   frame_done         one-cycle pulse when the frame completes
// -----------------------------------------------------------------------------
module wave_renderer #(
  parameter int CHANNELS = 5,
  parameter int STEPS    = 15,
  parameter int TOPOFS   = 10,
  parameter int LEFTOFS  = 10,
  parameter int WHEIGHT  = 20,
  parameter int WWIDTH   = 20,
  parameter int WVSTEP   = 50,
  parameter int XMAX     = 239,
  parameter int YMAX     = 319
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        clear_en,
  input  logic [15:0]                 bg_color,
  input  logic [16*CHANNELS-1:0]      chan_color,
  input  logic [CHANNELS*STEPS-1:0]   samples,
  output logic                        draw,
  input  logic                        draw_done,
  output logic [15:0]                 color,
  output logic [15:0]                 xstart,
  output logic [15:0]                 ystart,
  output logic [15:0]                 xend,
  output logic [15:0]                 yend,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SW  = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int IW  = (CHANNELS * STEPS > 1) ? $clog2(CHANNELS * STEPS) : 1;
  localparam int CCW = $clog2(16 * CHANNELS);

  typedef enum logic [2:0] {IDLE, CLEAR, HBIT, VERT, NEXT, FIN} state_e;

  typedef struct packed {
    logic [15:0] color;
    logic [15:0] xs;
    logic [15:0] ys;
    logic [15:0] xe;
    logic [15:0] ye;
  } cmd_t;

  state_e                      state_q, state_d;
  logic [CW-1:0]               c_q, c_d;
  logic [SW-1:0]               s_q, s_d;
  logic                        draw_q, draw_d;
  cmd_t                        cmd_q, cmd_d;
  logic [CHANNELS*STEPS-1:0]   samples_q;
  logic [16*CHANNELS-1:0]      chan_color_q;
  logic [15:0]                 bg_color_q;

  // Level of channel c at step s, taken from the frame snapshot.
  function automatic logic level(input logic [CW-1:0] c, input logic [SW-1:0] s);
    return samples_q[IW'(int'(c) * STEPS + int'(s))];
  endfunction

  // Rectangle for a drawing state at (c, s). All geometry wraps modulo 2^16.
  function automatic cmd_t make_cmd(input state_e kind, input logic [CW-1:0] c,
                                    input logic [SW-1:0] s);
    logic [15:0] xhi, xlo, y, col;
    cmd_t        cmd;
    xhi = 16'(XMAX - TOPOFS) - 16'(int'(c) * WVSTEP);
    xlo = xhi - 16'(WHEIGHT);
    y   = 16'(LEFTOFS) + 16'(int'(s) * WWIDTH);
    col = chan_color_q[CCW'(16 * int'(c)) +: 16];
    cmd = '0;
    case (kind)
      CLEAR: begin
        cmd.color = bg_color_q;
        cmd.xe    = 16'(XMAX);
        cmd.ye    = 16'(YMAX);
      end
      HBIT: begin
        cmd.color = col;
        cmd.xs    = level(c, s) ? xhi : xlo;
        cmd.xe    = cmd.xs;
        cmd.ys    = y;
        cmd.ye    = y + 16'(WWIDTH);
      end
      VERT: begin
        cmd.color = col;
        cmd.xs    = xlo;
        cmd.xe    = xhi;
        cmd.ys    = y;
        cmd.ye    = y;
      end
      default: cmd = '0;
    endcase
    return cmd;
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    s_d     = s_q;
    draw_d  = draw_q;
    cmd_d   = cmd_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = clear_en ? CLEAR : HBIT;
          c_d     = '0;
          s_d     = '0;
          draw_d  = 1'b0;
        end
      end
      CLEAR, HBIT, VERT: begin
        // Entered with draw low only from IDLE or straight after a completed
        // command: load the rectangle and raise draw. Once draw is high the
        // command is frozen until draw_done.
        if (!draw_q) begin
          draw_d = 1'b1;
          cmd_d  = make_cmd(state_q, c_q, s_q);
        end else if (draw_done) begin
          draw_d  = 1'b0;
          state_d = (state_q == HBIT) ? NEXT : HBIT;
        end
      end
      NEXT: begin
        if (s_q != SW'(STEPS - 1)) begin
          s_d     = s_q + 1'b1;
          state_d = (level(c_q, s_q) != level(c_q, s_d)) ? VERT : HBIT;
        end else if (c_q != CW'(CHANNELS - 1)) begin
          c_d     = c_q + 1'b1;
          s_d     = '0;
          state_d = HBIT;
        end else begin
          state_d = FIN;
        end
        // Preload the next command so draw rises on entry to its state.
        if (state_d != FIN) begin
          draw_d = 1'b1;
          cmd_d  = make_cmd(state_d, c_d, s_d);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      c_q          <= '0;
      s_q          <= '0;
      draw_q       <= 1'b0;
      cmd_q        <= '0;
      // NOTE: the frame snapshot is reset too; it is small, and a defined
      // value keeps post-reset behaviour deterministic in simulation.
      samples_q    <= '0;
      chan_color_q <= '0;
      bg_color_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      s_q     <= s_d;
      draw_q  <= draw_d;
      cmd_q   <= cmd_d;
      if (state_q == IDLE && start) begin
        samples_q    <= samples;
        chan_color_q <= chan_color;
        bg_color_q   <= bg_color;
      end
    end
  end

  assign draw       = draw_q;
  assign color      = cmd_q.color;
  assign xstart     = cmd_q.xs;
  assign ystart     = cmd_q.ys;
  assign xend       = cmd_q.xe;
  assign yend       = cmd_q.ye;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == FIN);

endmodule
